// File: rtl/div_share_if.sv
// Bundle between div_share_ctrl, the two EX pipes and the shared iterative divider.
//
// Handshakes:
//  - Pipe side: req_valid[i] presents an op. The pipe stays in EX while pause[i] is high.
//    res_valid[i]/res_data[i] hold the result until consume[i] is pulsed.
//  - Divider side: div_start is a single-cycle pulse. It is only issued when div_running is low.
//    Operands are sampled in that cycle. div_done is a single-cycle pulse that qualifies
//    div_quotient/div_remainder.
interface div_share_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
);
  logic [1:0]             req_valid;
  logic [1:0][PC_W-1:0]   req_pc;
  logic [1:0]             req_signed;
  logic [1:0]             req_rem;
  logic [1:0][DATA_W-1:0] req_dividend;
  logic [1:0][DATA_W-1:0] req_divisor;
  logic [1:0]             consume;
  logic                   flush;
  logic [1:0]             pause;
  logic [1:0]             res_valid;
  logic [1:0][DATA_W-1:0] res_data;
  logic                   div_start;
  logic                   div_op;
  logic [DATA_W-1:0]      div_dividend;
  logic [DATA_W-1:0]      div_divisor;
  logic                   div_running;
  logic                   div_done;
  logic [DATA_W-1:0]      div_quotient;
  logic [DATA_W-1:0]      div_remainder;

  // Environment view: pipes and divider drive requests and responses
  modport master (
    output req_valid, req_pc, req_signed, req_rem, req_dividend, req_divisor,
           consume, flush, div_running, div_done, div_quotient, div_remainder,
    input  pause, res_valid, res_data, div_start, div_op, div_dividend, div_divisor
  );

  // Controller view
  modport slave (
    input  req_valid, req_pc, req_signed, req_rem, req_dividend, req_divisor,
           consume, flush, div_running, div_done, div_quotient, div_remainder,
    output pause, res_valid, res_data, div_start, div_op, div_dividend, div_divisor
  );
endinterface

// File: rtl/div_share_ctrl.sv
// Shares one iterative divider between the two EX pipes.
// Pipe 0 is older and wins arbitration. Each result is buffered per pipe,
// tagged by PC, until that pipe leaves EX.
module div_share_ctrl #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
) (
  input  logic        clk,
  input  logic        rst,        // asynchronous, active-low
  div_share_if.slave  bus,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]             state;
  logic [1:0]             res_vld;
  logic [1:0][DATA_W-1:0] res_buf;
  logic [1:0][PC_W-1:0]   res_pc;
  logic                   owner;
  logic                   own_rem;
  logic [PC_W-1:0]        own_pc;

  logic [1:0] stale;
  logic [1:0] pending;
  logic       g;
  logic       go;
  logic       zero_div;
  logic       capture;

  // Arbitration. A buffer whose PC no longer matches the instruction in EX is stale.
  // That pipe counts as pending again in the same cycle.
  always_comb begin
    stale   = 2'b00;
    pending = 2'b00;
    for (int i = 0; i < 2; i++) begin
      stale[i]   = bus.req_valid[i] & res_vld[i] & (bus.req_pc[i] != res_pc[i]);
      pending[i] = bus.req_valid[i] & (~res_vld[i] | stale[i]);
    end
    g        = ~pending[0];
    go       = rst & (state == S_IDLE) & (|pending) & ~bus.div_running & ~bus.flush;
    zero_div = (bus.req_divisor[g] == '0);
    capture  = (state == S_RUN) & bus.div_done & ~bus.flush;
  end

  // Divider drive and pipe-facing outputs
  always_comb begin
    bus.div_start    = go & ~zero_div;
    bus.div_op       = bus.req_signed[g];
    bus.div_dividend = bus.req_dividend[g];
    bus.div_divisor  = bus.req_divisor[g];
    bus.pause        = pending;
    bus.res_valid    = res_vld;
    for (int i = 0; i < 2; i++) begin
      bus.res_data[i] = res_vld[i] ? res_buf[i] : '0;
    end
    dbg_state = state;
  end

  // Sequencer. DRAIN waits out a flushed divide, because the divider cannot be aborted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      owner   <= 1'b0;
      own_rem <= 1'b0;
      own_pc  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (go && !zero_div) begin
            owner   <= g;
            own_rem <= bus.req_rem[g];
            own_pc  <= bus.req_pc[g];
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          if (bus.flush && !bus.div_done) state <= S_DRAIN;
          else if (bus.div_done)          state <= S_IDLE;
        end
        S_DRAIN: begin
          if (bus.div_done) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Per-pipe result buffers. Flush dominates, then a capture, then invalidation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_vld <= 2'b00;
      res_buf <= '0;
      res_pc  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (bus.flush) begin
          res_vld[i] <= 1'b0;
        end else if (capture && owner == i[0]) begin
          res_vld[i] <= 1'b1;
          res_buf[i] <= own_rem ? bus.div_remainder : bus.div_quotient;
          res_pc[i]  <= own_pc;
        end else if (go && zero_div && g == i[0]) begin
          res_vld[i] <= 1'b1;
          res_buf[i] <= '0;
          res_pc[i]  <= bus.req_pc[i];
        end else if (bus.consume[i] || stale[i]) begin
          res_vld[i] <= 1'b0;
        end
      end
    end
  end

endmodule
